// File: rtl/mapa_port_arbiter_if.sv
// Requester-side bundle for the map RAM arbiter: video read port plus the
// update and spawner read/write ports.
interface mapa_port_arbiter_if;
  logic       vid_req;
  logic [9:0] vid_x;
  logic [9:0] vid_y;
  logic       vid_gnt;
  logic       vid_rvalid;
  logic [1:0] vid_rdata;

  logic       upd_req;
  logic       upd_we;
  logic [9:0] upd_x;
  logic [9:0] upd_y;
  logic [1:0] upd_wdata;
  logic       upd_gnt;
  logic       upd_rvalid;
  logic [1:0] upd_rdata;

  logic       spn_req;
  logic       spn_we;
  logic [9:0] spn_x;
  logic [9:0] spn_y;
  logic [1:0] spn_wdata;
  logic       spn_gnt;
  logic       spn_rvalid;
  logic [1:0] spn_rdata;

  modport master (
    output vid_req, vid_x, vid_y,
    input  vid_gnt, vid_rvalid, vid_rdata,
    output upd_req, upd_we, upd_x, upd_y, upd_wdata,
    input  upd_gnt, upd_rvalid, upd_rdata,
    output spn_req, spn_we, spn_x, spn_y, spn_wdata,
    input  spn_gnt, spn_rvalid, spn_rdata
  );

  modport slave (
    input  vid_req, vid_x, vid_y,
    output vid_gnt, vid_rvalid, vid_rdata,
    input  upd_req, upd_we, upd_x, upd_y, upd_wdata,
    output upd_gnt, upd_rvalid, upd_rdata,
    input  spn_req, spn_we, spn_x, spn_y, spn_wdata,
    output spn_gnt, spn_rvalid, spn_rdata
  );
endinterface

// File: rtl/mapa_port_arbiter.sv
// Map RAM port arbiter: video (priority, starvation-limited), round-robin
// update/spawner access, and a hardware clear sweep. RAM outputs are
// registered; read data is routed back through a 2-stage requester tag pipe.
module mapa_port_arbiter #(
  parameter int unsigned MAPA_WIDTH   = 40,
  parameter int unsigned MAPA_HEIGHT  = 30,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mapa_port_arbiter_if.slave   bus,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic                 oob_err,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic [1:0]           ram_wdata,
  input  logic [1:0]           ram_rdata
);

  localparam int unsigned CELLS    = MAPA_WIDTH * MAPA_HEIGHT;
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic {
    ST_ARB,
    ST_CLEAR
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_UPD,
    TAG_SPN
  } tag_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [9:0] x,
                                                   input logic [9:0] y);
    logic [20:0] lin;
    lin = 21'(y) * 21'(MAPA_WIDTH) + 21'(x);
    return lin[ADDR_W-1:0];
  endfunction

  function automatic logic in_range(input logic [9:0] x, input logic [9:0] y);
    return (32'(x) < MAPA_WIDTH) && (32'(y) < MAPA_HEIGHT);
  endfunction

  state_t              state_q, state_d;
  logic                rr_spn_q, rr_spn_d;     // 0: update wins a tie, 1: spawner
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [1:0]          ram_wdata_q, ram_wdata_d;
  logic                oob_q, oob_d;
  logic                done_q, done_d;
  tag_t                tag1_q, tag1_d, tag2_q;
  logic                zero1_q, zero1_d, zero2_q;

  logic g_vid, g_upd, g_spn, sweep_wr;
  logic waiting, starved;
  logic vid_in, upd_in, spn_in;

  // Arbitration, RAM command formation and next-state for all control flops
  always_comb begin
    g_vid       = 1'b0;
    g_upd       = 1'b0;
    g_spn       = 1'b0;
    sweep_wr    = 1'b0;
    waiting     = 1'b0;
    state_d     = state_q;
    rr_spn_d    = rr_spn_q;
    starve_d    = starve_q;
    sweep_d     = sweep_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = '0;
    oob_d       = 1'b0;
    done_d      = 1'b0;
    tag1_d      = TAG_NONE;
    zero1_d     = 1'b0;

    vid_in  = in_range(bus.vid_x, bus.vid_y);
    upd_in  = in_range(bus.upd_x, bus.upd_y);
    spn_in  = in_range(bus.spn_x, bus.spn_y);
    starved = (starve_q == STARVE_MAX);

    // Grants are held off while reset is asserted so every output reads 0.
    if (reset) begin
      unique case (state_q)
        ST_ARB: begin
          waiting = bus.upd_req | bus.spn_req;
          if (bus.vid_req && !(starved && waiting)) begin
            g_vid = 1'b1;
          end else if (bus.upd_req && (!bus.spn_req || !rr_spn_q)) begin
            g_upd = 1'b1;
          end else if (bus.spn_req) begin
            g_spn = 1'b1;
          end
          if (clear_start) begin
            state_d = ST_CLEAR;
            sweep_d = '0;
          end
        end
        ST_CLEAR: begin
          // The sweep behaves as a permanently waiting requester.
          waiting = 1'b1;
          if (bus.vid_req && !starved) begin
            g_vid = 1'b1;
          end else begin
            sweep_wr = 1'b1;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end

    if (g_vid) begin
      ram_addr_d = cell_addr(bus.vid_x, bus.vid_y);
      oob_d      = !vid_in;
      tag1_d     = TAG_VID;
      zero1_d    = !vid_in;
    end else if (g_upd) begin
      ram_addr_d  = cell_addr(bus.upd_x, bus.upd_y);
      ram_we_d    = bus.upd_we & upd_in;
      ram_wdata_d = bus.upd_wdata;
      oob_d       = !upd_in;
      tag1_d      = bus.upd_we ? TAG_NONE : TAG_UPD;
      zero1_d     = !upd_in;
    end else if (g_spn) begin
      ram_addr_d  = cell_addr(bus.spn_x, bus.spn_y);
      ram_we_d    = bus.spn_we & spn_in;
      ram_wdata_d = bus.spn_wdata;
      oob_d       = !spn_in;
      tag1_d      = bus.spn_we ? TAG_NONE : TAG_SPN;
      zero1_d     = !spn_in;
    end else if (sweep_wr) begin
      ram_addr_d = sweep_q;
      ram_we_d   = 1'b1;
      sweep_d    = sweep_q + 1'b1;
      if (sweep_q == LAST_ADDR) begin
        state_d = ST_ARB;
        done_d  = 1'b1;
      end
    end

    if (g_upd) begin
      rr_spn_d = 1'b1;
    end else if (g_spn) begin
      rr_spn_d = 1'b0;
    end

    if (g_upd || g_spn || sweep_wr || !waiting) begin
      starve_d = '0;
    end else if (g_vid) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // State, RAM command and read-tag pipeline registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_ARB;
      rr_spn_q    <= 1'b0;
      starve_q    <= '0;
      sweep_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      oob_q       <= 1'b0;
      done_q      <= 1'b0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      zero1_q     <= 1'b0;
      zero2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_spn_q    <= rr_spn_d;
      starve_q    <= starve_d;
      sweep_q     <= sweep_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      oob_q       <= oob_d;
      done_q      <= done_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      zero1_q     <= zero1_d;
      zero2_q     <= zero1_q;
    end
  end

  // Output mapping; read data is suppressed unless its tag selects the port
  always_comb begin
    bus.vid_gnt    = g_vid;
    bus.upd_gnt    = g_upd;
    bus.spn_gnt    = g_spn;
    bus.vid_rvalid = (tag2_q == TAG_VID);
    bus.upd_rvalid = (tag2_q == TAG_UPD);
    bus.spn_rvalid = (tag2_q == TAG_SPN);
    bus.vid_rdata  = (bus.vid_rvalid && !zero2_q) ? ram_rdata : 2'b00;
    bus.upd_rdata  = (bus.upd_rvalid && !zero2_q) ? ram_rdata : 2'b00;
    bus.spn_rdata  = (bus.spn_rvalid && !zero2_q) ? ram_rdata : 2'b00;
    clear_busy     = (state_q == ST_CLEAR);
    clear_done     = done_q;
    oob_err        = oob_q;
    ram_addr       = ram_addr_q;
    ram_we         = ram_we_q;
    ram_wdata      = ram_wdata_q;
  end

endmodule
